// File: rtl/mac_seq_ctrl_if.sv
// Command, operand, MAC-side and result signals of mac_seq_ctrl.
// master is the sequencer's view; slave is the view of the surrounding logic.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_acc;

  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;

  logic             mac_start;
  logic             mac_clear;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [31:0]      mac_acc;
  logic             mac_done;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_err;

  logic             busy;

  modport master (
    input  cmd_valid, cmd_len, cmd_acc,
    input  op_valid, op_a, op_b,
    input  mac_acc, mac_done,
    input  res_ready,
    output cmd_ready, op_ready,
    output mac_start, mac_clear, mac_a, mac_b,
    output res_valid, res_data, res_err,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_acc,
    output op_valid, op_a, op_b,
    output mac_acc, mac_done,
    output res_ready,
    input  cmd_ready, op_ready,
    input  mac_start, mac_clear, mac_a, mac_b,
    input  res_valid, res_data, res_err,
    input  busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Streams operand pairs into mac_unit as start pulses and returns the final accumulator.
// Operand-starvation timeout is compiled in only when MAC_SEQ_TIMEOUT_EN is defined.
module mac_seq_ctrl #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("mac_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] done_cnt;
  logic             mac_start;
  logic             mac_clear;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [31:0]      res_data;

  logic             in_run;
  logic             in_job;
  logic             op_fire;
  logic             done_fire;
  logic             last_issue;
  logic             last_done;

  assign in_run     = (state == RUN);
  assign in_job     = (state == RUN) || (state == WAIT);
  assign op_fire    = bus.op_valid && bus.op_ready;
  assign done_fire  = in_job && bus.mac_done;
  assign last_issue = (issue_cnt + LEN_W'(1)) == len;
  // The done pulse of the final pair also carries the final accumulator value.
  assign last_done  = done_fire && (issue_cnt == len) && ((done_cnt + LEN_W'(1)) == len);

  assign bus.cmd_ready = rst_n && (state == IDLE);
  assign bus.op_ready  = in_run && (issue_cnt < len);
  assign bus.mac_start = mac_start;
  assign bus.mac_clear = mac_clear;
  assign bus.mac_a     = mac_a;
  assign bus.mac_b     = mac_b;
  assign bus.res_valid = (state == RESP);
  assign bus.res_data  = res_data;
  assign bus.busy      = (state != IDLE);

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            res_err;
  logic            timeout_hit;
  logic            drained;

  assign timeout_hit = in_run && !bus.op_valid &&
                       (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // All issued pairs have completed, so there is no done pulse left to wait for.
  assign drained     = (done_cnt + LEN_W'(bus.mac_done)) == issue_cnt;
  assign bus.res_err = res_err;

  always_ff @(posedge clk) begin
    if (!rst_n || !in_run || bus.op_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign bus.res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      issue_cnt <= '0;
      done_cnt  <= '0;
      mac_start <= 1'b0;
      mac_clear <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_data  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
      res_err   <= 1'b0;
`endif
    end else begin
      mac_start <= op_fire;
      mac_clear <= 1'b0;
      if (op_fire) begin
        mac_a     <= bus.op_a;
        mac_b     <= bus.op_b;
        issue_cnt <= issue_cnt + LEN_W'(1);
      end
      if (done_fire) begin
        done_cnt <= done_cnt + LEN_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            len       <= bus.cmd_len;
            issue_cnt <= '0;
            done_cnt  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
            if (!bus.cmd_acc) begin
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end else if (bus.cmd_len == '0) begin
              res_data <= bus.mac_acc;
              state    <= RESP;
            end else begin
              state <= RUN;
            end
          end
        end

        CLEAR: begin
          if (len == '0) begin
            res_data <= '0;
            state    <= RESP;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (op_fire && last_issue) begin
            state <= WAIT;
          end
`ifdef MAC_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            len     <= issue_cnt;
            res_err <= 1'b1;
            if (drained) begin
              res_data <= bus.mac_acc;
              state    <= RESP;
            end else begin
              state <= WAIT;
            end
          end
`endif
        end

        WAIT: begin
          if (last_done) begin
            res_data <= bus.mac_acc;
            state    <= RESP;
          end
        end

        RESP: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed, table-driven bench for mac_seq_ctrl with a behavioural 8x8->32 MAC attached.
module tb_mac_seq_ctrl;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO = 8;
  localparam int NV = 7;
`else
  localparam int TO = 1024;
  localparam int NV = 6;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.LEN_W(16)) bus ();

  mac_seq_ctrl #(.LEN_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // MAC: one-cycle latency, done pulses with the updated accumulator.
  logic [31:0] acc_m;
  logic        done_m;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_m  <= '0;
      done_m <= 1'b0;
    end else begin
      done_m <= bus.mac_start;
      if (bus.mac_clear) acc_m <= '0;
      else if (bus.mac_start) acc_m <= acc_m + 32'(bus.mac_a) * 32'(bus.mac_b);
    end
  end
  assign bus.mac_acc  = acc_m;
  assign bus.mac_done = done_m;

  typedef struct {
    string           name;
    logic            acc;
    int              len;
    int              nsup;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              gap;
    int              hold;
    bit              nag;
    logic [31:0]     exp_data;
    logic            exp_err;
  } job_t;

  job_t jobs [NV];

  int n_pass  = 0;
  int n_total = 0;

  int          r_starts, r_clears, r_overlap, r_bad_busy, r_unstable;
  int          r_first_acc, r_last_acc, r_rv_after, r_total;
  bit          r_done;
  logic [31:0] r_data;
  logic        r_err, r_post_busy, r_post_rdy;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic job_t mk(input string name, input logic acc, input int len, input int nsup,
                              input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3,
                              input int gap, input int hold, input bit nag,
                              input logic [31:0] exp_data, input logic exp_err);
    job_t j;
    j.name = name;  j.acc = acc;   j.len = len;   j.nsup = nsup;
    j.a[0] = 8'(a0); j.a[1] = 8'(a1); j.a[2] = 8'(a2); j.a[3] = 8'(a3);
    j.b[0] = 8'(b0); j.b[1] = 8'(b1); j.b[2] = 8'(b2); j.b[3] = 8'(b3);
    j.gap = gap;    j.hold = hold; j.nag = nag;
    j.exp_data = exp_data; j.exp_err = exp_err;
    return j;
  endfunction

  // Called at a negedge with the DUT idle; the command is accepted at edge 0 and
  // t counts the edge that follows each negedge.
  task automatic run_job(input job_t j);
    int          idx, gapcnt;
    bit          offer, will_acc, rr, fin;
    logic [31:0] held_d;
    logic        held_e;
    idx = 0; gapcnt = 0; fin = 0; held_d = '0; held_e = 1'b0;
    r_starts = 0; r_clears = 0; r_overlap = 0; r_bad_busy = 0; r_unstable = 0;
    r_first_acc = -1; r_last_acc = -1; r_rv_after = -1; r_total = -1;
    r_done = 0; r_data = '0; r_err = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 16'(j.len);
    bus.cmd_acc   = j.acc;
    @(negedge clk);
    bus.cmd_valid = j.nag;
    if (j.nag) begin
      bus.cmd_len = 16'd5;
      bus.cmd_acc = 1'b0;
    end
    for (int t = 1; t <= 400 && !fin; t++) begin
      if (bus.mac_start) r_starts++;
      if (bus.mac_clear) r_clears++;
      if (bus.mac_start && bus.mac_clear) r_overlap++;
      if (bus.cmd_ready || !bus.busy) r_bad_busy++;
      offer = (idx < j.nsup) && (gapcnt == 0);
      bus.op_valid = offer;
      if (offer) begin
        bus.op_a = j.a[idx];
        bus.op_b = j.b[idx];
      end
      will_acc = offer && bus.op_ready;
      if (will_acc) begin
        if (r_first_acc < 0) r_first_acc = t;
        r_last_acc = t;
        idx++;
        gapcnt = j.gap;
      end else if (!offer && gapcnt > 0) begin
        gapcnt--;
      end
      if (bus.res_valid) begin
        if (r_rv_after < 0) begin
          r_rv_after = t - 1;
          held_d = bus.res_data;
          held_e = bus.res_err;
        end else if (bus.res_data !== held_d || bus.res_err !== held_e) begin
          r_unstable++;
        end
      end
      rr = bus.res_valid && (t - 1 - r_rv_after >= j.hold);
      bus.res_ready = rr;
      if (rr) begin
        r_data  = bus.res_data;
        r_err   = bus.res_err;
        r_total = t;
        r_done  = 1;
        fin     = 1;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    r_post_busy   = bus.busy;
    r_post_rdy    = bus.cmd_ready;
  endtask

  task automatic check_job(input job_t j);
    run_job(j);
    check({j.name, " completed"},       64'(r_done),     64'd1);
    check({j.name, " res_data"},        64'(r_data),     64'(j.exp_data));
    check({j.name, " res_err"},         64'(r_err),      64'(j.exp_err));
    check({j.name, " mac_start count"}, 64'(r_starts),   64'(j.nsup));
    check({j.name, " mac_clear count"}, 64'(r_clears),   j.acc ? 64'd0 : 64'd1);
    check({j.name, " start+clear"},     64'(r_overlap),  64'd0);
    check({j.name, " busy/cmd_ready"},  64'(r_bad_busy), 64'd0);
    check({j.name, " result stable"},   64'(r_unstable), 64'd0);
    if (j.gap == 0 && j.hold == 0 && j.nsup == j.len && j.len > 0) begin
      check({j.name, " first op accept edge"}, 64'(r_first_acc), j.acc ? 64'd1 : 64'd2);
      check({j.name, " last op to res_valid"}, 64'(r_rv_after - r_last_acc), 64'd2);
      check({j.name, " cmd to result cycles"}, 64'(r_total), 64'(j.len + (j.acc ? 3 : 4)));
    end
    check({j.name, " busy after result"},      64'(r_post_busy), 64'd0);
    check({j.name, " cmd_ready after result"}, 64'(r_post_rdy),  64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  acc_n, seen_rv;
    bit  rdy;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_acc = 1'b0;
    bus.op_valid  = 1'b0; bus.op_a    = '0; bus.op_b    = '0;
    bus.res_ready = 1'b0;

    // 1*2 + 3*4 + 5*6 + 255*255 = 65069; +10*10 + 2*3 = 65175; gapped 1+4+9 = 14; +4*5 = 34
    jobs[0] = mk("clr4",   1'b0, 4, 4, 1, 3, 5, 255, 2, 4, 6, 255, 0, 0, 0, 32'd65069, 1'b0);
    jobs[1] = mk("acc2",   1'b1, 2, 2, 10, 2, 0, 0, 10, 3, 0, 0,   0, 0, 0, 32'd65175, 1'b0);
    jobs[2] = mk("acc0",   1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 32'd65175, 1'b0);
    jobs[3] = mk("clr0",   1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 32'd0,     1'b0);
    jobs[4] = mk("gap3",   1'b0, 3, 3, 1, 2, 3, 0, 1, 2, 3, 0,     2, 5, 1, 32'd14,    1'b0);
    jobs[5] = mk("acc1",   1'b1, 1, 1, 4, 0, 0, 0, 5, 0, 0, 0,     0, 0, 0, 32'd34,    1'b0);
`ifdef MAC_SEQ_TIMEOUT_EN
    jobs[6] = mk("tmo4",   1'b0, 4, 2, 2, 3, 0, 0, 2, 3, 0, 0,     0, 0, 0, 32'd13,    1'b1);
`endif

    repeat (3) @(negedge clk);
    check("reset cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("reset outputs",
          64'({bus.op_ready, bus.mac_start, bus.mac_clear, bus.mac_a, bus.mac_b,
               bus.res_valid, bus.res_data, bus.res_err, bus.busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("idle busy",      64'(bus.busy),      64'd0);

    for (int i = 0; i < NV; i++) check_job(jobs[i]);

    // Reset in the middle of a five-pair job after two pairs.
    bus.cmd_valid = 1'b1; bus.cmd_len = 16'd5; bus.cmd_acc = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    acc_n = 0;
    for (int k = 0; k < 20 && acc_n < 2; k++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = 8'(acc_n + 3);
      bus.op_b     = 8'd2;
      rdy = bus.op_ready;
      @(negedge clk);
      if (rdy) acc_n++;
    end
    bus.op_valid = 1'b0;
    check("midjob operands accepted", 64'(acc_n), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midjob reset outputs",
          64'({bus.cmd_ready, bus.op_ready, bus.mac_start, bus.mac_clear, bus.mac_a, bus.mac_b,
               bus.res_valid, bus.res_data, bus.res_err, bus.busy}), 64'd0);
    rst_n   = 1'b1;
    seen_rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid) seen_rv++;
    end
    check("no result after reset", 64'(seen_rv), 64'd0);
    check("idle after reset", 64'({bus.busy, bus.cmd_ready}), 64'd1);
    check_job(mk("clr1", 1'b0, 1, 1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 32'd49, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
